wb_write_queue: RTL
===================

Name: wb_write_queue

Overview:
- Write-back queue directly upstream of the 8 x 8-bit register file.
- Buffers register-write requests from the datapath using a valid/ready handshake and drains them in order, one per cycle, onto the register file write port (wa3/we3/wd3).
- Provides a combinational forwarding lookup, so readers see values that are queued but not yet written.

Parameters:
- DEPTH, 4, number of pending-write entries (power of 2, >= 2).
- DW, 8, data width; matches the register file word.
- AW, 4, write-address width; matches the register file wa3.
- NREG, 8, number of implemented registers; valid addresses are 0..NREG-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  a write request is present.
- in_ready  out  1  the queue can accept a request; equals ~full.
- in_addr  in  AW  destination register of the request.
- in_data  in  DW  value to write.
- drain_en  in  1  when 1, drain is allowed this cycle; when 0, drain is stalled.
- wa3  out  AW  register file write address (registered).
- we3  out  1  register file write enable (registered).
- wd3  out  DW  register file write data (registered).
- ra  in  AW  forwarding lookup address.
- fwd_hit  out  1  a pending write to ra exists.
- fwd_data  out  DW  newest pending value for ra.
- count  out  log2(DEPTH)+1  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- addr_err  out  1  sticky flag: an out-of-range write was dropped.

Behaviour:
- Reset (rst=1 at a posedge):
  - All entries are invalidated; pointers and count go to 0.
  - empty=1, full=0, in_ready=1, addr_err=0.
  - we3=0, wa3=0, wd3=0.
  - Reset dominates push and pop on the same edge.
  - Reset mid-operation discards all pending writes, and we3 is 0 in the following cycle.
- Push:
  - Occurs when in_valid && in_ready at a posedge with in_addr < NREG.
  - The entry is written at the tail; order is strictly FIFO.
  - Writes to the same register are not coalesced.
- Out-of-range write:
  - Occurs when in_valid && in_ready with in_addr >= NREG.
  - The handshake completes, nothing is enqueued, and addr_err is set to 1 and held until reset.
- in_ready = ~full, taken from registered state only.
  - When full, no push occurs even if a pop happens on the same edge; there is no pass-through.
- Pop: at a posedge where drain_en=1 and count>0 (pre-edge value):
  - The head is removed.
  - we3<=1, wa3<=head addr, wd3<=head data.
- No pop (drain_en=0 or empty): we3<=0; wa3/wd3 hold their previous values.
- Simultaneous push and pop: count unchanged; both take effect.
- count/full/empty are registered and consistent with the post-edge occupancy.
- Latency:
  - A request accepted at edge N is popped no earlier than edge N+1.
  - we3 is high in the cycle after edge N+1.
  - The register file captures it at edge N+2.
  - Back-to-back pops give one write per cycle.
- Pointer wrap: head and tail wrap modulo DEPTH; count disambiguates full from empty.
- Forwarding (combinational from ra and current state):
  - Candidates are the valid queue entries plus the output stage (when we3=1, since the register file has not yet captured it).
  - Priority is newest first: youngest queue entry, then older entries, then the output stage.
  - On a match: fwd_hit=1 and fwd_data = matched data.
  - Otherwise: fwd_hit=0 and fwd_data=0.
  - ra >= NREG always gives fwd_hit=0.
  - A request being pushed on the current edge is not visible to forwarding until after that edge.

Test Plan:
- Reset, then push (addr 3, data 0xA5) with drain_en=1:
  - in_ready=1 throughout.
  - One cycle after the push edge: we3=1, wa3=3, wd3=0xA5.
  - Next cycle: we3=0.
  - Register D3 reads 0xA5.
- drain_en=0, push 4 writes (addr 1..4, data 0x11..0x44):
  - full=1, in_ready=0, count=4.
  - A fifth in_valid is not accepted.
  - Raise drain_en: we3=1 for exactly 4 consecutive cycles, with wa3=1,2,3,4 in order, then empty=1.
- drain_en=0, push (addr 5, 0x10) then (addr 5, 0x20); set ra=5:
  - fwd_hit=1, fwd_data=0x20.
  - Drain both: while (5, 0x20) is in the output stage, fwd_data=0x20; after that, fwd_hit=0.
- Push with in_addr=9:
  - Handshake completes; count unchanged; no we3 pulse; addr_err=1 until rst.
- Full queue with drain_en=1 and in_valid held:
  - Pushes resume one cycle after the first pop; count stays at 3/4 in steady state.
  - Pointer wrap is verified over 10 writes, with wa3 order matching the push order.
- Assert rst while 3 entries are pending and we3=1:
  - Next cycle: we3=0, count=0, empty=1, fwd_hit=0.
  - No further register file writes occur.

Source files
------------

// File: rtl/wb_write_queue.sv
// Write-back queue ahead of the register file: buffers datapath writes, drains them in
// order onto wa3/we3/wd3, and forwards the newest pending value for a lookup address.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int NREG  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     drain_en,
    output logic [AW-1:0]            wa3,
    output logic                     we3,
    output logic [DW-1:0]            wd3,
    input  logic [AW-1:0]            ra,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     addr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count_nxt;
    logic          push_hs;
    logic          in_range;
    logic          push;
    logic          pop;

    // Handshake completes even for out-of-range addresses; only in-range ones are stored.
    assign in_ready = ~full;
    assign push_hs  = in_valid & ~full;
    assign in_range = {1'b0, in_addr} < NREG_L;
    assign push     = push_hs & in_range;
    assign pop      = drain_en & ~empty;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + (PW+1)'(1);
        else if (pop && !push)
            count_nxt = count - (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= in_addr;
            q_data[tail] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            addr_err <= 1'b0;
            we3      <= 1'b0;
            wa3      <= '0;
            wd3      <= '0;
        end else begin
            if (push)
                tail <= tail + PW'(1);
            if (pop) begin
                head <= head + PW'(1);
                we3  <= 1'b1;
                wa3  <= q_addr[head];
                wd3  <= q_data[head];
            end else begin
                we3  <= 1'b0;
            end
            if (push_hs && !in_range)
                addr_err <= 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (PW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Scan oldest to youngest so the newest match wins; the output stage is oldest of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if ({1'b0, ra} < NREG_L) begin
            if (we3 && (wa3 == ra)) begin
                fwd_hit  = 1'b1;
                fwd_data = wd3;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (((PW+1)'(k) < count) && (q_addr[head + PW'(k)] == ra)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = q_data[head + PW'(k)];
                end
            end
        end
    end

endmodule
